mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL provide parameter MEM_WAIT, default 1, number of cycles a store holds mem_write (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  begin fetching instructions (sampled in IDLE only).
REQ-005 SHALL provide port halt  input  1  stop after the current instruction completes.
REQ-006 SHALL provide port instr  input  32  instruction register contents from datapath, valid from DECODE onward.
REQ-007 SHALL provide ports pc_write, ir_write, reg_write, mem_write  output  1 each  datapath strobes.
REQ-008 SHALL provide port alu_op  output  4  ALU operation select.
REQ-009 SHALL provide ports alu_src_imm, reg_dst_rd, imm_zero_ext  output  1 each  mux and extend selects.
REQ-010 SHALL provide port mem_size  output  2  store width: 00 byte, 01 half, 10 word.
REQ-011 SHALL provide ports busy, instr_done, illegal  output  1 each  status.
REQ-012 SHALL provide port instr_count  output  16  completed-instruction counter.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR; outputs Moore-decoded from state plus fields latched in DECODE.
REQ-014 IDLE: start=1 -> FETCH; else stay; busy=0 only in IDLE and ERR.
REQ-015 FETCH: ir_write=1, pc_write=1 for exactly one cycle -> DECODE.
REQ-016 DECODE: latch instr[31:26] (opcode) and instr[5:0] (funct); legal -> EXEC, illegal -> ERR.
REQ-017 Legal R-type (opcode 000000), funct -> alu_op: sll 000000->0101, srl 000010->0110, sra 000011->0111, and 000100->0011, or 000101->0100, add 100000->0000, addu 100001->0001, sub 100010->0010, sltu 101011->1000; any other funct illegal.
REQ-018 Legal I-type: addi 001000 (alu_op 0000, sign-ext), andi 001100 (0011, zero-ext), ori 001101 (0100, zero-ext), sb 101000, sh 101001, sw 101011 (all stores 0001, sign-ext); any other opcode illegal.
REQ-019 EXEC: one cycle, alu_op/alu_src_imm/imm_zero_ext valid; ALU-class -> WB, store -> MEM.
REQ-020 WB: reg_write=1 one cycle; reg_dst_rd=1 for R-type, 0 for I-type.
REQ-021 MEM: mem_write=1 and mem_size valid for exactly MEM_WAIT consecutive cycles via internal 4-bit down-counter loaded on EXEC->MEM.
REQ-022 instr_done SHALL pulse one cycle in WB and in the final MEM cycle; instr_count increments in that cycle, wrapping 0xFFFF->0x0000.
REQ-023 After the completing cycle: halt=1 -> IDLE, else -> FETCH; halt outside that cycle has no effect.
REQ-024 Latency: ALU instruction 4 cycles FETCH-to-FETCH; store 3+MEM_WAIT cycles.
REQ-025 ERR: illegal=1, no strobes asserted, instr_count unchanged; leaves only by reset.
REQ-026 Outside their stated states, all strobes SHALL be 0; alu_op/mem_size SHALL hold last decoded values.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, all outputs 0, alu_op=0000, mem_size=00, instr_count=0, MEM counter 0, latched fields 0, regardless of state (including mid-MEM).
REQ-028 First edge after reset deassertion SHALL evaluate IDLE rules normally.

Verification
REQ-029 start pulse, instr=0x00221820 (add) , halt=1 during WB -> FETCH,DECODE,EXEC(alu_op 0000),WB(reg_write, reg_dst_rd=1), instr_count=1, IDLE.
REQ-030 instr=0x30010FFF (andi), halt=0 -> alu_op 0011, imm_zero_ext=1, alu_src_imm=1, reg_dst_rd=0, back to FETCH after 4 cycles.
REQ-031 MEM_WAIT=3, instr=0xA4010001 (sh) -> mem_write high exactly 3 cycles, mem_size=01, instr_done on 3rd, total 6 cycles.
REQ-032 instr=0x00000007 (funct 000111) -> ERR, illegal=1, stays through 10 cycles with start pulses, cleared only by reset.
REQ-033 reset asserted in 2nd MEM cycle of sw -> outputs 0 asynchronously, instr_count=0, IDLE; subsequent start runs normally.
REQ-034 preload 65535 completions (loop ALU instructions) -> next completion wraps instr_count to 0x0000.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing,
// R-type and I-type decode to ALU selects, store write-hold counter and completion count.
module mips_multicycle_control #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] instr,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_dst_rd,
  output logic        imm_zero_ext,
  output logic [1:0]  mem_size,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_fetch  = 3'd1,
    st_decode = 3'd2,
    st_exec   = 3'd3,
    st_mem    = 3'd4,
    st_wb     = 3'd5,
    st_err    = 3'd6
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       store;
    logic       imm;
    logic       zext;
    logic [3:0] alu_op;
    logic [1:0] size;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      6'b000000: begin
        case (fn)
          6'b000000: d.alu_op = 4'b0101;
          6'b000010: d.alu_op = 4'b0110;
          6'b000011: d.alu_op = 4'b0111;
          6'b000100: d.alu_op = 4'b0011;
          6'b000101: d.alu_op = 4'b0100;
          6'b100000: d.alu_op = 4'b0000;
          6'b100001: d.alu_op = 4'b0001;
          6'b100010: d.alu_op = 4'b0010;
          6'b101011: d.alu_op = 4'b1000;
          default:   d.legal  = 1'b0;
        endcase
      end
      6'b001000: begin d.imm = 1'b1; d.alu_op = 4'b0000; end
      6'b001100: begin d.imm = 1'b1; d.zext = 1'b1; d.alu_op = 4'b0011; end
      6'b001101: begin d.imm = 1'b1; d.zext = 1'b1; d.alu_op = 4'b0100; end
      6'b101000: begin d.imm = 1'b1; d.store = 1'b1; d.alu_op = 4'b0001; d.size = 2'b00; end
      6'b101001: begin d.imm = 1'b1; d.store = 1'b1; d.alu_op = 4'b0001; d.size = 2'b01; end
      6'b101011: begin d.imm = 1'b1; d.store = 1'b1; d.alu_op = 4'b0001; d.size = 2'b10; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t     state_r;
  state_t     nxt_state_s;
  logic [3:0] cnt_r;
  logic [3:0] nxt_cnt_s;
  logic [5:0] opcode_r;
  logic [5:0] funct_r;
  dec_t       dec_s;
  logic       done_s;
  logic       unused_s;

  // funct is kept for the datapath view only; rs/rt/rd/imm bits are the datapath's business
  assign unused_s = ^{instr[25:6], funct_r};

  // next-state, store-hold counter and completion detection
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    done_s      = 1'b0;
    dec_s       = decode(instr[31:26], instr[5:0]);
    case (state_r)
      st_idle: begin
        if (start) nxt_state_s = st_fetch;
        else       nxt_state_s = st_idle;
      end
      st_fetch:  nxt_state_s = st_decode;
      st_decode: begin
        if (dec_s.legal) nxt_state_s = st_exec;
        else             nxt_state_s = st_err;
      end
      st_exec: begin
        // legal stores are the only decoded opcodes with bit 5 set
        if (opcode_r[5]) begin
          nxt_state_s = st_mem;
          nxt_cnt_s   = 4'(MEM_WAIT);
        end else begin
          nxt_state_s = st_wb;
        end
      end
      st_mem: begin
        if (cnt_r <= 4'd1) begin
          done_s      = 1'b1;
          nxt_cnt_s   = 4'd0;
          nxt_state_s = halt ? st_idle : st_fetch;
        end else begin
          nxt_cnt_s   = cnt_r - 4'd1;
        end
      end
      st_wb: begin
        done_s      = 1'b1;
        nxt_state_s = halt ? st_idle : st_fetch;
      end
      st_err:  nxt_state_s = st_err;
      default: nxt_state_s = st_err;
    endcase
  end

  // state, latched fields and Moore outputs registered from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= st_idle;
      cnt_r        <= 4'd0;
      opcode_r     <= 6'd0;
      funct_r      <= 6'd0;
      pc_write     <= 1'b0;
      ir_write     <= 1'b0;
      reg_write    <= 1'b0;
      mem_write    <= 1'b0;
      alu_op       <= 4'b0000;
      alu_src_imm  <= 1'b0;
      reg_dst_rd   <= 1'b0;
      imm_zero_ext <= 1'b0;
      mem_size     <= 2'b00;
      busy         <= 1'b0;
      instr_done   <= 1'b0;
      illegal      <= 1'b0;
      instr_count  <= 16'd0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      if (state_r == st_decode) begin
        opcode_r <= instr[31:26];
        funct_r  <= instr[5:0];
      end
      if (nxt_state_s == st_exec) begin
        alu_op <= dec_s.alu_op;
        if (dec_s.store) mem_size <= dec_s.size;
      end
      pc_write     <= (nxt_state_s == st_fetch);
      ir_write     <= (nxt_state_s == st_fetch);
      reg_write    <= (nxt_state_s == st_wb);
      mem_write    <= (nxt_state_s == st_mem);
      alu_src_imm  <= (nxt_state_s == st_exec) && dec_s.imm;
      imm_zero_ext <= (nxt_state_s == st_exec) && dec_s.zext;
      reg_dst_rd   <= (nxt_state_s == st_wb) && (opcode_r == 6'b000000);
      busy         <= (nxt_state_s != st_idle) && (nxt_state_s != st_err);
      illegal      <= (nxt_state_s == st_err);
      instr_done   <= (nxt_state_s == st_wb) ||
                      ((nxt_state_s == st_mem) && (nxt_cnt_s == 4'd1));
      if (done_s) instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-instruction expected cycle
// sequences built from the opcode/funct tables, with randomized instruction streams.
module tb_mips_multicycle_control;

  localparam int MW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        pc_write, ir_write, reg_write, mem_write;
  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_dst_rd, imm_zero_ext;
  logic [1:0]  mem_size;
  logic        busy, instr_done, illegal;
  logic [15:0] instr_count;

  int          vectors = 0;
  int          errors  = 0;
  logic [3:0]  m_alu_op = 4'd0;
  logic [1:0]  m_mem_size = 2'd0;
  logic [15:0] m_count = 16'd0;

  mips_multicycle_control #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .instr(instr),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_dst_rd(reg_dst_rd),
    .imm_zero_ext(imm_zero_ext), .mem_size(mem_size), .busy(busy),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obsv();
    return {pc_write, ir_write, reg_write, mem_write, alu_src_imm, reg_dst_rd,
            imm_zero_ext, busy, instr_done, illegal, alu_op, mem_size, instr_count};
  endfunction

  function automatic logic [31:0] expv(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic asi, input logic rdd,
                                       input logic zx, input logic bz, input logic dn,
                                       input logic il);
    return {pcw, irw, rw, mw, asi, rdd, zx, bz, dn, il, m_alu_op, m_mem_size, m_count};
  endfunction

  // Instruction-set table: which encodings are legal and what they select
  function automatic void ref_decode(input logic [31:0] ins, output bit legal, output bit st,
                                     output bit rt, output bit im, output bit zx,
                                     output logic [3:0] aop, output logic [1:0] sz);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    legal = 1'b1; st = 1'b0; rt = 1'b0; im = 1'b1; zx = 1'b0; aop = 4'd0; sz = 2'd0;
    case (op)
      6'd0: begin
        rt = 1'b1; im = 1'b0;
        case (fn)
          6'b000000: aop = 4'd5;
          6'b000010: aop = 4'd6;
          6'b000011: aop = 4'd7;
          6'b000100: aop = 4'd3;
          6'b000101: aop = 4'd4;
          6'b100000: aop = 4'd0;
          6'b100001: aop = 4'd1;
          6'b100010: aop = 4'd2;
          6'b101011: aop = 4'd8;
          default:   legal = 1'b0;
        endcase
      end
      6'b001000: aop = 4'd0;
      6'b001100: begin aop = 4'd3; zx = 1'b1; end
      6'b001101: begin aop = 4'd4; zx = 1'b1; end
      6'b101000: begin aop = 4'd1; st = 1'b1; sz = 2'd0; end
      6'b101001: begin aop = 4'd1; st = 1'b1; sz = 2'd1; end
      6'b101011: begin aop = 4'd1; st = 1'b1; sz = 2'd2; end
      default:   legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [5:0] ops [6];
    logic [5:0] fns [9];
    logic [31:0] w;
    int k;
    ops = '{6'b001000, 6'b001100, 6'b001101, 6'b101000, 6'b101001, 6'b101011};
    fns = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
            6'b100000, 6'b100001, 6'b100010, 6'b101011};
    w = $urandom;
    k = $urandom_range(0, 14);
    if (k < 9) begin w[31:26] = 6'd0; w[5:0] = fns[k]; end
    else       w[31:26] = ops[k-9];
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0;
    @(posedge clk); #1;
    m_alu_op = 4'd0; m_mem_size = 2'd0; m_count = 16'd0;
    reset = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; the next edge must enter FETCH.
  task automatic run_instr(input logic [31:0] ins, input bit halt_end, input string tag);
    bit legal, st, rt, im, zx, last;
    logic [3:0] aop;
    logic [1:0] sz;
    logic [31:0] ev, ov;
    int ncyc;
    ref_decode(ins, legal, st, rt, im, zx, aop, sz);
    instr = ins;
    start = 1'b1;
    ncyc = !legal ? 3 : (st ? 3 + MW : 4);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      last = (c == ncyc - 1);
      if (c == 0)      ev = expv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      else if (c == 1) ev = expv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      else if (c == 2 && !legal) ev = expv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (c == 2) begin
        m_alu_op = aop;
        if (st) m_mem_size = sz;
        ev = expv(0, 0, 0, 0, im, 0, zx, 1, 0, 0);
      end
      else if (!st) ev = expv(0, 0, 1, 0, 0, rt, 0, 1, 1, 0);
      else          ev = expv(0, 0, 0, 1, 0, 0, 0, 1, last, 0);
      ov = obsv();
      vectors++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL %s instr=%h cycle %0d: got %h want %h", tag, ins, c, ov, ev);
      end
      if (legal && last) begin
        halt = halt_end; start = 1'b0; m_count = m_count + 16'd1;
      end else begin
        halt = 1'($urandom); start = 1'($urandom);
      end
    end
    if (legal && halt_end) begin
      @(posedge clk); #1;
      ev = expv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ov = obsv();
      vectors++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL %s_idle: got %h want %h", tag, ov, ev);
      end
      halt = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] ov;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ov = obsv();
      vectors++;
      if (ov !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h want 00000000", i, ov);
      end
    end
  endtask

  task automatic test_add();
    run_instr(32'h00221820, 1'b1, "add_halt");
  endtask

  task automatic test_andi();
    run_instr(32'h30010FFF, 1'b0, "andi");
    run_instr(32'h00221820, 1'b1, "after_andi");
  endtask

  task automatic test_store();
    run_instr(32'hA4010001, 1'b0, "sh");
    run_instr(32'hA0220003, 1'b0, "sb");
    run_instr(32'hAC018004, 1'b0, "sw");
    run_instr(32'h00411022, 1'b1, "after_store");
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 300; i++)
      run_instr(rand_legal(), ($urandom_range(0, 7) == 0), "rand");
    run_instr(32'h00221820, 1'b1, "rand_end");
  endtask

  task automatic test_wrap();
    // seed the counter just below its wrap point instead of retiring 65k instructions
    force dut.instr_count = 16'hFFFD;
    #1;
    release dut.instr_count;
    m_count = 16'hFFFD;
    run_instr(rand_legal(), 1'b0, "wrap_a");
    run_instr(rand_legal(), 1'b0, "wrap_b");
    run_instr(32'h34010001, 1'b1, "wrap_c");
    run_instr(32'h00221820, 1'b1, "wrap_d");
  endtask

  task automatic test_reset_mid_mem();
    logic [31:0] ov;
    instr = 32'hAC010001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({mem_write, mem_size, instr_done} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_mem_store: got %b want 1100", {mem_write, mem_size, instr_done});
    end
    #2 reset = 1'b1;
    #1;
    ov = obsv();
    vectors++;
    if (ov !== 32'd0) begin
      errors++;
      $display("FAIL mid_mem_async_reset: got %h want 00000000", ov);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_alu_op = 4'd0; m_mem_size = 2'd0; m_count = 16'd0;
    run_instr(32'h00221820, 1'b1, "after_mid_reset");
  endtask

  task automatic test_illegal();
    logic [31:0] w, ov, ev;
    bit legal, st, rt, im, zx;
    logic [3:0] aop;
    logic [1:0] sz;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) w = 32'h00000007;
      else begin
        do begin
          w = $urandom;
          if (n < 4) w[31:26] = 6'd0;
          ref_decode(w, legal, st, rt, im, zx, aop, sz);
        end while (legal);
      end
      run_instr(w, 1'b0, "illegal");
      for (int i = 0; i < 10; i++) begin
        start = 1'($urandom);
        halt = 1'($urandom);
        @(posedge clk); #1;
        ev = expv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ov = obsv();
        vectors++;
        if (ov !== ev) begin
          errors++;
          $display("FAIL err_hold instr=%h cycle %0d: got %h want %h", w, i, ov, ev);
        end
      end
      do_reset();
      ov = obsv();
      vectors++;
      if (ov !== 32'd0) begin
        errors++;
        $display("FAIL err_reset: got %h want 00000000", ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_andi();
    test_store();
    test_random_stream();
    test_wrap();
    test_reset_mid_mem();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
